// File: rtl/iis_pkg.sv
// Shared defaults and lrclk slot encoding for the I2S receiver.
package iis_pkg;
  localparam int DATA_W_DEF     = 24;
  localparam int SLOT_BCLKS_DEF = 32;
  localparam int BCLK_DIV_DEF   = 32;

  localparam logic LEFT  = 1'b0;
  localparam logic RIGHT = 1'b1;
endpackage

// File: rtl/iis_rx_core_if.sv
// Sample bus from the I2S receiver to downstream processing.
interface iis_rx_core_if #(
  parameter int DATA_W = iis_pkg::DATA_W_DEF
) ();
  logic [DATA_W-1:0] ldata_l;
  logic [DATA_W-1:0] rdata_l;
  logic              sample_vld;

  modport master (output ldata_l, rdata_l, sample_vld);
  modport slave  (input  ldata_l, rdata_l, sample_vld);
endinterface

// File: rtl/iis_clk_gen.sv
// bclk/lrclk generation from the system clock, plus bit counter and rise strobe.
module iis_clk_gen import iis_pkg::*; #(
  parameter int BCLK_DIV   = BCLK_DIV_DEF,
  parameter int SLOT_BCLKS = SLOT_BCLKS_DEF,
  localparam int CW = $clog2(BCLK_DIV),
  localparam int BW = $clog2(SLOT_BCLKS)
) (
  input  logic          clk_100m,
  input  logic          rst,
  output logic          bclk,
  output logic          lrclk,
  output logic [BW-1:0] bitcnt,
  output logic          rise
);
  localparam int HALF = BCLK_DIV / 2;

  logic [CW-1:0] cnt;
  logic          wrap;

  assign wrap = (cnt == CW'(BCLK_DIV - 1));
  assign rise = (cnt == CW'(HALF));

  // bclk/lrclk/bitcnt all update on the same edge as cnt, so lrclk and
  // bitcnt move exactly with the bclk falling edge.
  always_ff @(posedge clk_100m) begin
    if (rst) begin
      cnt    <= '0;
      bclk   <= 1'b0;
      lrclk  <= LEFT;
      bitcnt <= '0;
    end else begin
      cnt <= wrap ? '0 : cnt + 1'b1;
      if (cnt == CW'(HALF - 1)) bclk <= 1'b1;
      else if (wrap)            bclk <= 1'b0;
      if (wrap) begin
        if (bitcnt == BW'(SLOT_BCLKS - 1)) begin
          bitcnt <= '0;
          lrclk  <= ~lrclk;
        end else begin
          bitcnt <= bitcnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/iis_rx_core.sv
// I2S master-mode receiver: deserialises sdata_i into left/right sample registers.
// Define SDATA_SYNC_EN to add a 2-flop synchroniser on sdata_i (+2 cycles latency).
module iis_rx_core import iis_pkg::*; #(
  parameter int BCLK_DIV   = BCLK_DIV_DEF,
  parameter int SLOT_BCLKS = SLOT_BCLKS_DEF,
  parameter int DATA_W     = DATA_W_DEF
) (
  input  logic          clk_100m,
  input  logic          rst,
  input  logic          sdata_i,
  output logic          bclk,
  output logic          lrclk,
  iis_rx_core_if.master smp
);
  localparam int BW = $clog2(SLOT_BCLKS);

  logic [BW-1:0]     bitcnt;
  logic              rise;
  logic              sd;
  logic              take;
  logic              in_word;
  logic              last_bit;
  logic [DATA_W-1:0] sr;
  logic [DATA_W-1:0] word;

  iis_clk_gen #(.BCLK_DIV(BCLK_DIV), .SLOT_BCLKS(SLOT_BCLKS)) u_clk_gen (
    .clk_100m (clk_100m),
    .rst      (rst),
    .bclk     (bclk),
    .lrclk    (lrclk),
    .bitcnt   (bitcnt),
    .rise     (rise)
  );

`ifdef SDATA_SYNC_EN
  localparam int STAGES = 2;
  logic [1:0] sync;
  always_ff @(posedge clk_100m) begin
    if (rst) sync <= '0;
    else     sync <= {sync[0], sdata_i};
  end
  assign sd = sync[1];
`else
  localparam int STAGES = 0;
  assign sd = sdata_i;
`endif

  // Rise strobe delayed to line up with the synchroniser output. bitcnt and
  // lrclk only move at the wrap, well after the delayed sample point.
  logic [STAGES:0] vld_pipe;
  assign vld_pipe[0] = rise;
  generate
    if (STAGES > 0) begin : g_dly
      always_ff @(posedge clk_100m) begin
        if (rst) vld_pipe[STAGES:1] <= '0;
        else     vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      end
    end
  endgenerate
  assign take = vld_pipe[STAGES];

  // bitcnt 0 carries the previous word's trailing bit (I2S one-bit delay).
  assign in_word  = (bitcnt != '0) && (bitcnt <= BW'(DATA_W));
  assign last_bit = (bitcnt == BW'(DATA_W));
  assign word     = {sr[DATA_W-2:0], sd};

  always_ff @(posedge clk_100m) begin
    if (rst) begin
      sr             <= '0;
      smp.ldata_l    <= '0;
      smp.rdata_l    <= '0;
      smp.sample_vld <= 1'b0;
    end else begin
      smp.sample_vld <= 1'b0;
      if (take && in_word) sr <= word;
      if (take && last_bit) begin
        smp.sample_vld <= 1'b1;
        if (lrclk == LEFT) smp.ldata_l <= word;
        else               smp.rdata_l <= word;
      end
    end
  end
endmodule

// File: tb/tb_iis_rx_core.sv
// Directed bench for iis_rx_core: reset, clock ratios, fixed/random words, mid-word reset.
module tb_iis_rx_core;
  import iis_pkg::*;

  localparam int DW = 24;
`ifdef SDATA_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  typedef struct {
    logic          ch;
    logic [DW-1:0] w;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sdata = 1'b0;
  logic bclk, lrclk;

  int   npass = 0;
  int   nchk  = 0;
  int   cyc   = 0;
  bit   mon_en = 1'b0;
  int   vld_cnt = 0;
  int   vcyc_q[$];
  exp_t exp_q[$];
  logic [DW-1:0] last_l = '0;
  logic [DW-1:0] last_r = '0;

  iis_rx_core_if #(.DATA_W(DW)) smp ();

  iis_rx_core #(.BCLK_DIV(32), .SLOT_BCLKS(32), .DATA_W(DW)) dut (
    .clk_100m (clk),
    .rst      (rst),
    .sdata_i  (sdata),
    .bclk     (bclk),
    .lrclk    (lrclk),
    .smp      (smp)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Scoreboard: every pulse must match the next expected word; the other channel must hold.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && mon_en && smp.sample_vld) begin
      vld_cnt++;
      vcyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        chk("vld_unexpected", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("vld_chan", {31'd0, lrclk}, {31'd0, e.ch});
        if (e.ch == LEFT) last_l = e.w;
        else              last_r = e.w;
        chk("ldata", {8'd0, smp.ldata_l}, {8'd0, last_l});
        chk("rdata", {8'd0, smp.rdata_l}, {8'd0, last_r});
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    vcyc_q.delete();
    vld_cnt = 0;
    last_l  = '0;
    last_r  = '0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_fall();
    logic p;
    p = bclk;
    for (int i = 0; i < 128; i++) begin
      @(negedge clk);
      if (p && !bclk) return;
      p = bclk;
    end
    chk("bclk_fall_timeout", 32'd0, 32'd1);
  endtask

  // Called at the start of a left slot (bitcnt 0, bclk low). Bit b of a slot
  // carries word[DW-b] for b=1..DW; all other bit times get random junk.
  task automatic drive_slots(input int nslots, input bit rnd, input logic [DW-1:0] lw,
                             input logic [DW-1:0] rw, input int abort_at);
    logic          ch;
    logic [DW-1:0] w;
    logic [31:0]   r;
    for (int s = 0; s < nslots; s++) begin
      ch = logic'(s % 2);
      r  = $urandom;
      w  = rnd ? r[DW-1:0] : (ch ? rw : lw);
      for (int b = 0; b < 32; b++) begin
        if (s * 32 + b == abort_at) return;
        if (b >= 1 && b <= DW) sdata = w[DW-b];
        else                   sdata = logic'($urandom_range(0, 1));
        if (b == DW) exp_q.push_back('{ch, w});
        wait_fall();
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t;
    int rises, lr_edges, highs;
    logic pb, pl;

    // Reset state and first-edge timing
    do_reset();
    chk("rst_bclk", {31'd0, bclk}, 32'd0);
    chk("rst_lrclk", {31'd0, lrclk}, 32'd0);
    chk("rst_ldata", {8'd0, smp.ldata_l}, 32'd0);
    chk("rst_rdata", {8'd0, smp.rdata_l}, 32'd0);
    chk("rst_vld", {31'd0, smp.sample_vld}, 32'd0);
    t = 0;
    while (!bclk && t < 100) begin @(negedge clk); t++; end
    chk("first_rise_cyc", cyc, 32'd16);
    t = 0;
    while (!lrclk && t < 2000) begin @(negedge clk); t++; end
    chk("first_lrclk_cyc", cyc, 32'd1024);

    // Clock ratios over 4096 cycles
    rises = 0; lr_edges = 0; highs = 0;
    pb = bclk; pl = lrclk;
    for (int i = 0; i < 4096; i++) begin
      @(negedge clk);
      if (!pb && bclk) rises++;
      if (pl != lrclk) lr_edges++;
      if (bclk) highs++;
      pb = bclk; pl = lrclk;
    end
    chk("bclk_periods", rises, 32'd128);
    chk("lrclk_edges", lr_edges, 32'd4);
    chk("bclk_high_cycles", highs, 32'd2048);

    // Fixed pattern: left A5C3F0, right 0F1E2D
    do_reset();
    mon_en = 1'b1;
    drive_slots(2, 1'b0, 24'hA5C3F0, 24'h0F1E2D, -1);
    chk("fix_vld_cnt", vld_cnt, 32'd2);
    chk("fix_vld_cyc_l", (vcyc_q.size() > 0) ? vcyc_q[0] : -1, 32'(785 + LAT));
    chk("fix_vld_cyc_r", (vcyc_q.size() > 1) ? vcyc_q[1] : -1, 32'(1809 + LAT));
    chk("fix_ldata", {8'd0, smp.ldata_l}, 32'h00A5C3F0);
    chk("fix_rdata", {8'd0, smp.rdata_l}, 32'h000F1E2D);
    chk("fix_exp_left", exp_q.size(), 32'd0);

    // Random stream, three frames, continuing from the fixed frame
    drive_slots(6, 1'b1, '0, '0, -1);
    chk("rnd_vld_cnt", vld_cnt, 32'd8);
    chk("rnd_exp_left", exp_q.size(), 32'd0);

    // Reset during right slot bit 10; no pulse, rdata cleared, next left word good
    drive_slots(2, 1'b1, '0, '0, 32 + 10);
    repeat (3) @(negedge clk);
    do_reset();
    chk("mid_rdata", {8'd0, smp.rdata_l}, 32'd0);
    chk("mid_ldata", {8'd0, smp.ldata_l}, 32'd0);
    chk("mid_lrclk", {31'd0, lrclk}, 32'd0);
    drive_slots(1, 1'b0, 24'h5A1234, '0, -1);
    chk("mid_vld_cnt", vld_cnt, 32'd1);
    chk("mid_vld_cyc", (vcyc_q.size() > 0) ? vcyc_q[0] : -1, 32'(785 + LAT));
    chk("mid_ldata_after", {8'd0, smp.ldata_l}, 32'h005A1234);
    chk("mid_rdata_after", {8'd0, smp.rdata_l}, 32'd0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
